// File: rtl/truth_sweep4.sv
// truth_sweep4: exhaustive 4-input sweep driver that captures and checks a truth table
module truth_sweep4 #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        s,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic        pass,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    state_t      state_q, state_d;
    logic [3:0]  idx_q;
    logic [7:0]  hold_q;
    logic [15:0] exp_q;
    logic [15:0] table_q;
    logic [4:0]  cnt_q;
    logic [3:0]  ff_q;
    logic        seen_q;
    logic        pass_q;
    logic        accept;
    logic        sample;
    logic        last;
    logic        miss;
    // s is sampled on the final hold cycle of each vector
    assign accept = state_q == IDLE && start;
    assign sample = state_q == APPLY && hold_q == HOLD_LAST;
    assign last   = sample && idx_q == 4'd15;
    assign miss   = sample && (s != exp_q[idx_q]);
    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // next-state: DONE lasts exactly one cycle, start is only heard in IDLE
    always_comb begin
        state_d = accept ? APPLY :
                  last ? DONE :
                  state_q == DONE ? IDLE : state_q;
    end
    // outputs decoded from state; the vector is only driven while applying
    always_comb begin
        {a, b, c, d}   = state_q == APPLY ? idx_q : 4'd0;
        busy           = state_q != IDLE;
        done           = state_q == DONE;
        table_out      = table_q;
        pass           = pass_q;
        mismatch_count = cnt_q;
        first_fail     = ff_q;
    end
    // sweep datapath: index/hold stepping, capture and mismatch bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            hold_q  <= '0;
            exp_q   <= '0;
            table_q <= '0;
            cnt_q   <= '0;
            ff_q    <= '0;
            seen_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            hold_q  <= '0;
            exp_q   <= expected;
            table_q <= '0;
            cnt_q   <= '0;
            ff_q    <= '0;
            seen_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (sample) begin
            table_q[idx_q] <= s;
            hold_q         <= '0;
            cnt_q          <= cnt_q + {4'd0, miss};
            ff_q           <= (miss && !seen_q) ? idx_q : ff_q;
            seen_q         <= seen_q | miss;
            idx_q          <= last ? idx_q : idx_q + 4'd1;
            pass_q         <= last ? (cnt_q == 5'd0 && !miss) : pass_q;
        end else if (state_q == APPLY) begin
            hold_q <= hold_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_truth_sweep4.sv
// tb_truth_sweep4: directed checks of truth_sweep4 at hold 1 and hold 3
module tb_truth_sweep4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic [15:0] expected = 16'h0;
    logic [15:0] model_tbl = 16'hAC3C;
    logic        s_zero = 1'b0;
    logic        s1, s3;
    logic [3:0]  vec1, vec3;
    logic        busy1, busy3, done1, done3, pass1, pass3;
    logic [15:0] tbl1, tbl3;
    logic [4:0]  cnt1, cnt3;
    logic [3:0]  ff1, ff3;
    int          checks = 0;
    int          errors = 0;
    int          dc;

    always #5 clk = ~clk;

    assign s1 = s_zero ? 1'b0 : model_tbl[vec1];
    assign s3 = s_zero ? 1'b0 : model_tbl[vec3];

    truth_sweep4 #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .expected(expected), .s(s1),
        .a(vec1[3]), .b(vec1[2]), .c(vec1[1]), .d(vec1[0]),
        .busy(busy1), .done(done1), .table_out(tbl1), .pass(pass1),
        .mismatch_count(cnt1), .first_fail(ff1)
    );

    truth_sweep4 #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .expected(expected), .s(s3),
        .a(vec3[3]), .b(vec3[2]), .c(vec3[1]), .d(vec3[0]),
        .busy(busy3), .done(done3), .table_out(tbl3), .pass(pass3),
        .mismatch_count(cnt3), .first_fail(ff3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // runs one sweep; poke > 0 re-pulses start and scrambles expected in that cycle
    task automatic sweep(input int h, input logic [15:0] ex, input int poke, output int done_cyc);
        int bad;
        logic [3:0] v;
        bad = 0;
        done_cyc = -1;
        @(negedge clk);
        expected = ex;
        if (h == 1) start1 = 1'b1; else start3 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        start3 = 1'b0;
        for (int n = 1; n <= 16 * h + 20 && done_cyc < 0; n++) begin
            @(negedge clk);
            if (n == poke) begin
                start1 = 1'b1;
                expected = 16'hFFFF;
            end else if (n == poke + 1) begin
                start1 = 1'b0;
            end
            v = h == 1 ? vec1 : vec3;
            if (h == 1 ? done1 : done3) done_cyc = n;
            else if (n <= 16 * h && (v != 4'((n - 1) / h) || !(h == 1 ? busy1 : busy3))) bad++;
        end
        check("vector_order", bad, 0);
        check("done_cycle", done_cyc, 16 * h + 1);
        check("busy_at_done", h == 1 ? busy1 : busy3, 1);
        check("vec_at_done", h == 1 ? vec1 : vec3, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_vec", vec1, 0);
        check("rst_table", tbl1, 0);
        check("rst_pass", pass1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_ff", ff1, 0);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        check("rst_over_start", busy1, 0);
        reset = 1'b0;

        sweep(1, 16'hAC3C, 0, dc);
        check("t1_table", tbl1, 16'hAC3C);
        check("t1_pass", pass1, 1);
        check("t1_cnt", cnt1, 0);
        check("t1_ff", ff1, 0);
        @(negedge clk);
        check("t1_done_pulse", done1, 0);
        check("t1_busy_idle", busy1, 0);
        check("t1_hold_table", tbl1, 16'hAC3C);

        sweep(1, 16'hAC3D, 0, dc);
        check("t2_table", tbl1, 16'hAC3C);
        check("t2_pass", pass1, 0);
        check("t2_cnt", cnt1, 1);
        check("t2_ff", ff1, 0);

        s_zero = 1'b1;
        sweep(1, 16'hAC3C, 0, dc);
        check("t3_table", tbl1, 16'h0000);
        check("t3_cnt", cnt1, 8);
        check("t3_ff", ff1, 2);
        check("t3_pass", pass1, 0);
        s_zero = 1'b0;

        sweep(3, 16'hAC3C, 0, dc);
        check("t4_table", tbl3, 16'hAC3C);
        check("t4_pass", pass3, 1);
        check("t4_cnt", cnt3, 0);

        sweep(1, 16'hAC3C, 6, dc);
        check("t5_table", tbl1, 16'hAC3C);
        check("t5_pass", pass1, 1);
        check("t5_cnt", cnt1, 0);
        @(negedge clk);
        check("t5_no_restart", busy1, 0);

        @(negedge clk);
        expected = 16'hAC3C;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_vec7", vec1, 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", busy1, 0);
        check("t6_vec", vec1, 0);
        check("t6_table", tbl1, 0);
        check("t6_cnt", cnt1, 0);
        check("t6_ff", ff1, 0);
        check("t6_pass", pass1, 0);
        check("t6_done", done1, 0);
        sweep(1, 16'hAC3C, 0, dc);
        check("t6_table2", tbl1, 16'hAC3C);
        check("t6_pass2", pass1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/truth_sweep4.md
# truth_sweep4

Sequential stimulus-and-capture stage that drives the four inputs `a`, `b`, `c`, `d` of a 4-input combinational function block and consumes its output `s`. On `start` it steps through all 16 input vectors in ascending order and holds each vector for a programmable number of cycles. It samples `s` into a 16-bit captured truth table and checks that table against an expected table. It replaces hand-written exhaustive testbench sweeps with a reusable in-design self-check stage placed directly upstream of the function block.

## Interface
Parameters:
- `HOLD_CYCLES`, default 1: cycles each vector is driven before `s` is sampled. Legal range 1..255; the hold counter is 8 bits.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep when the FSM is in IDLE; ignored otherwise.
- `expected`  in  16  reference table; bit i is the expected `s` for vector i. Latched on the accepted `start`.
- `s`  in  1  output of the function block under drive.
- `a`, `b`, `c`, `d`  out  1 each  vector index {a,b,c,d}, with `a` as the MSB.
- `busy`  out  1  high during the APPLY and DONE states.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_out`  out  16  captured `s` values; bit i corresponds to vector i.
- `pass`  out  1  `table_out == expected`. Valid from `done` until the next accepted `start`.
- `mismatch_count`  out  5  number of vectors that mismatched, 0..16.
- `first_fail`  out  4  lowest mismatching index; 0 when `pass` = 1.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE:
  - `a..d` = 0; `busy` = 0.
  - Results outputs hold their last values.
  - `start` = 1 moves to APPLY and performs the following in that same edge:
    - idx ← 0, hold ← 0;
    - `table_out` ← 0, `mismatch_count` ← 0, `first_fail` ← 0, `pass` ← 0;
    - latch `expected`.
- APPLY:
  - `{a,b,c,d}` = idx (registered).
  - Each cycle, hold increments until hold == `HOLD_CYCLES`−1. On that cycle:
    - `table_out[idx]` ← `s`;
    - on mismatch against `exp_q[idx]`: increment `mismatch_count`; if this is the first mismatch, `first_fail` ← idx;
    - if idx == 15, go to DONE; otherwise idx ← idx+1 and hold ← 0.
- DONE (one cycle):
  - `done` = 1; `busy` = 1; `a..d` = 0.
  - `pass` ← (final mismatch count == 0), computed including the index-15 sample.
  - Next state is IDLE.
- First-mismatch tracking uses an internal flag, cleared on start.
- The comparison always uses the latched `exp_q`. Changes on `expected` after start have no effect.
- `start` in APPLY or DONE is ignored and is not queued.
- `mismatch_count` never wraps: at most 16 increments, 5 bits.

## Timing
- Reset values, applied on the edge where `reset` = 1:
  - state IDLE;
  - `a..d` = 0, `busy` = 0, `done` = 0;
  - `table_out` = 0, `pass` = 0, `mismatch_count` = 0, `first_fail` = 0.
- Reset overrides `start` in the same cycle.
- Reset mid-sweep aborts immediately; partial results are discarded (all zero).
- Vector k is on `a..d` from cycle 1 + k·H through cycle (k+1)·H after the start edge, where H = `HOLD_CYCLES`.
- `s` is sampled at the last of those cycles. The function block is combinational, so `s` is settled.
- `done` is high in cycle 16·H + 1 after the start edge; `busy` is high in cycles 1..16·H+1.
- `start` is accepted again from cycle 16·H + 2. Back-to-back sweeps are therefore one IDLE cycle apart.

## Test plan
- Bench model s = function with table 0xAC3C, `expected` = 0xAC3C, H = 1, pulse start → `done` at cycle 17, `table_out` = 0xAC3C, `pass` = 1, `mismatch_count` = 0, `first_fail` = 0.
- Same model, `expected` = 0xAC3D → `pass` = 0, `mismatch_count` = 1, `first_fail` = 0, `table_out` = 0xAC3C.
- `s` tied 0, `expected` = 0xAC3C → `table_out` = 0x0000, `mismatch_count` = 8, `first_fail` = 2, `pass` = 0.
- H = 3, model 0xAC3C → each vector held exactly 3 cycles in order 0..15, `done` at cycle 49, `pass` = 1.
- During a sweep, pulse `start` at vector 5 and change `expected` to 0xFFFF → no restart; results computed against the latched value.
- Reset asserted while idx = 7 → next cycle all outputs 0 and state IDLE. A new start then runs a full sweep from vector 0 and passes.
